dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake and returns read data or a write completion after a programmable number of wait states.
- Replaces the zero-latency single-cycle data memory, so the pipeline can be exercised against a multi-cycle memory.
- Performs byte/half/word lane selection, store byte-enables and load sign/zero extension internally.

Parameters:
- ADDR_W, 8, word-index width; memory depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and for errors.
- resp_err  out  1  request rejected (misaligned, out of range, or illegal size); qualified by resp_valid.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0, latched request cleared. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch write/size/unsigned/addr/wdata. Go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
- WAIT:
  - req_ready=0.
  - Counter counts 1..WAIT_CYCLES; at WAIT_CYCLES, go to RESP.
  - req_valid is ignored; nothing is queued.
- RESP:
  - Lasts exactly one cycle, with resp_valid=1 and req_ready=0.
  - Array write (stores) and array read (loads) use the latched request on the IDLE/WAIT->RESP edge, so resp_rdata is registered and valid while resp_valid=1.
  - Next state is IDLE.
- Latency: accept edge at cycle T; resp_valid is high during cycle T+WAIT_CYCLES+1. Throughput is one request per WAIT_CYCLES+2 cycles.
- Error checks, evaluated on the latched request:
  - size=11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=00 is an error.
  - addr[31:ADDR_W+2]!=0 is an error.
  - On error: no array write, resp_rdata=0, resp_err=1.
- Stores:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Loads: select the lane(s) by addr[1:0], then sign- or zero-extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- resp_rdata and resp_err hold their values after the pulse until the next RESP. Consumers must qualify them with resp_valid.
- Reset mid-operation (WAIT or RESP entry not yet reached): the request is abandoned, no array write occurs, and outputs take their reset values immediately (asynchronously).
- A request arriving in the same cycle reset deasserts is accepted only if req_valid is still high at the first rising edge after deassertion.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings ST_IDLE, ST_WAIT, ST_RESP.
  - the 4-bit wait-counter width constant.
- One combinational sub-module, dmem_lane_align: inputs size, unsigned, addr[1:0], wdata, raw word. Outputs byte-enable[3:0], positioned write word, extended load data, misalign flag.
- The top level holds the FSM, the counter, request latches and the array.

Test Plan:
- Word round trip (WAIT_CYCLES=2): store 0xDEADBEEF @0x10, then word load @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0. resp_valid comes exactly 3 cycles after each accept edge; req_ready=0 for 3 cycles.
- Byte lanes: word store 0x00000000 @0x20, then byte store 0x80 @0x23. Signed byte load @0x23 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @0x20 -> 0x80000000.
- Half misaligned: half store 0x1234 @0x21 -> resp_err=1, resp_rdata=0. Word load @0x20 afterwards returns the prior contents unchanged.
- Out of range (ADDR_W=8): word load @0x400 -> resp_err=1. req_size=11 @0x0 -> resp_err=1.
- Busy-ignore: req_valid held high for 10 cycles with a constant load -> exactly 3 accepts (ready high at cycles 0, 4, 8 with WAIT_CYCLES=2) and 2 resp_valid pulses within the window.
- Reset mid-WAIT: word store 0xCAFEF00D @0x30, then assert rst in the first WAIT cycle -> outputs at reset values immediately. A later word load @0x30 returns the pre-store contents. With WAIT_CYCLES=0, the response arrives 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the multi-cycle data-memory responder: access sizes,
// FSM states and the wait-state counter width.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and positioned write word,
// load lane selection with sign/zero extension, and alignment checking.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = '0;
        case (addr_lo)
            2'd0:    ld_byte = raw[7:0];
            2'd1:    ld_byte = raw[15:8];
            2'd2:    ld_byte = raw[23:16];
            default: ld_byte = raw[31:24];
        endcase
        ld_half = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        byte_en  = '0;
        wr_word  = '0;
        ld_data  = '0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                wr_word = {4{wdata[7:0]}};
                ld_data = zero_ext ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_word  = {2{wdata[15:0]}};
                ld_data  = zero_ext ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
                misalign = addr_lo[0];
            end
            SZ_WORD: begin
                byte_en  = '1;
                wr_word  = wdata;
                ld_data  = raw;
                misalign = |addr_lo;
            end
            default: begin
                byte_en = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a programmable number of wait
// states; the array is accessed on the edge that enters the response state.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                state, state_n;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  go_resp;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        cur_write;
    logic [1:0]  cur_size;
    logic        cur_unsigned;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [ADDR_W-1:0] cur_idx;

    logic [3:0]  byte_en;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic [31:0] raw;
    logic        misalign;
    logic        err;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        go_resp    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_n = ST_RESP;
                    go_resp = 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                cnt          <= WAIT_CNT_W'(1);
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
            end else if (state == ST_WAIT && !go_resp) begin
                cnt <= cnt + WAIT_CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // With zero wait states the array is accessed on the accept edge itself,
    // so the live request bypasses the latches while in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_write    = req_write;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
        end else begin
            cur_write    = lat_write;
            cur_size     = lat_size;
            cur_unsigned = lat_unsigned;
            cur_addr     = lat_addr;
            cur_wdata    = lat_wdata;
        end
    end

    assign cur_idx = cur_addr[ADDR_W+1:2];
    assign raw     = mem[cur_idx];
    assign err     = (cur_size == 2'b11) || misalign || (|cur_addr[31:ADDR_W+2]);

    dmem_lane_align u_align (
        .size     (cur_size),
        .zero_ext (cur_unsigned),
        .addr_lo  (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .raw      (raw),
        .byte_en  (byte_en),
        .wr_word  (wr_word),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (go_resp && cur_write && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[cur_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (go_resp) begin
            resp_err   <= err;
            resp_rdata <= (err || cur_write) ? '0 : ld_data;
        end
    end

endmodule
